// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pll_reset_sequencer
//  Purpose  : Synchronises and debounces the PLL lock flag, then releases the
//             system reset and staggered per-core resets; re-asserts on loss.
//  Revision : 1.0  initial release
// ============================================================================
module pll_reset_sequencer #(
    parameter int LOCK_FILTER_CYCLES = 16,
    parameter int RESET_HOLD_CYCLES  = 1024,
    parameter int STAGGER_CYCLES     = 64,
    parameter int NUM_CORES          = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pll_locked,
    output logic                 sys_rst_n,
    output logic [NUM_CORES-1:0] core_rst_n,
    output logic                 ready,
    output logic [7:0]           lock_loss_count
);

    localparam int MAX_FH     = (LOCK_FILTER_CYCLES > RESET_HOLD_CYCLES) ?
                                LOCK_FILTER_CYCLES : RESET_HOLD_CYCLES;
    localparam int STAG_TOTAL = STAGGER_CYCLES * NUM_CORES;
    localparam int MAX_CNT    = (MAX_FH > STAG_TOTAL) ? MAX_FH : STAG_TOTAL;
    localparam int CNT_W      = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] c_filter_end  = CNT_W'(LOCK_FILTER_CYCLES);
    localparam logic [CNT_W-1:0] c_hold_end    = CNT_W'(RESET_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] c_stagger_end = CNT_W'(STAG_TOTAL);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_FILTER    = 3'd1,
        S_HOLD      = 3'd2,
        S_STAGGER   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 r_sync1;
    logic                 r_lk;
    logic                 w_loss;
    logic                 w_sys_nxt;
    logic [NUM_CORES-1:0] w_core_nxt;
    logic                 w_ready_nxt;

    // Next state, next counter and the registered-output decode of both.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_loss      = 1'b0;
        case (r_state)
            S_WAIT_LOCK: begin
                if (r_lk) begin
                    w_state_nxt = S_FILTER;
                    w_cnt_nxt   = c_one;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            S_FILTER: begin
                if (!r_lk) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_filter_end) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = c_one;
                end else begin
                    w_cnt_nxt   = r_cnt + c_one;
                end
            end
            S_HOLD: begin
                if (!r_lk) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_loss      = 1'b1;
                end else if (r_cnt == c_hold_end) begin
                    w_state_nxt = S_STAGGER;
                    w_cnt_nxt   = c_one;
                end else begin
                    w_cnt_nxt   = r_cnt + c_one;
                end
            end
            S_STAGGER: begin
                if (!r_lk) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_loss      = 1'b1;
                end else if (r_cnt == c_stagger_end) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_one;
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
                if (!r_lk) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_loss      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase

        // The stagger count starts at 1 on sys release, so core i is free once
        // the count passes STAGGER_CYCLES*(i+1).
        w_sys_nxt   = (w_state_nxt == S_STAGGER) || (w_state_nxt == S_RUN);
        w_ready_nxt = (w_state_nxt == S_RUN);
        for (int i = 0; i < NUM_CORES; i++) begin
            w_core_nxt[i] = (w_state_nxt == S_RUN) ||
                            ((w_state_nxt == S_STAGGER) &&
                             (w_cnt_nxt > CNT_W'(STAGGER_CYCLES * (i + 1))));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= S_WAIT_LOCK;
            r_cnt           <= '0;
            r_sync1         <= 1'b0;
            r_lk            <= 1'b0;
            sys_rst_n       <= 1'b0;
            core_rst_n      <= '0;
            ready           <= 1'b0;
            lock_loss_count <= 8'd0;
        end else begin
            r_sync1    <= pll_locked;
            r_lk       <= r_sync1;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            sys_rst_n  <= w_sys_nxt;
            core_rst_n <= w_core_nxt;
            ready      <= w_ready_nxt;
            if (w_loss && (lock_loss_count != 8'hFF)) begin
                lock_loss_count <= lock_loss_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire
